pc_seq: RTL and testbench
=========================

// Module: pc_seq
// PURPOSE
//  Program-counter sequencer feeding the 2:1 mux select/address path of the fetch stage.
//  Holds current PC, advances by +1, redirects on load, offers PC to fetch via valid/ready.
//  Its pc_out drives the mux that chooses sequential vs. branch address next cycle.
//  Three-state FSM (IDLE/RUN/HALT); optional hardware return-address stack.
// PARAMETERS
//  WIDTH        16   PC / address width in bits
//  RESET_VEC    0    PC value loaded on reset
//  STACK_DEPTH  4    return-stack entries (only used with CALL_STACK_EN; power of 2, >=2)
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      asynchronous, active-high reset
//  load         in   1      redirect request; PC <= load_addr
//  load_addr    in   WIDTH  redirect target
//  inc          in   1      advance request; PC <= PC+1
//  halt         in   1      enter HALT state
//  fetch_ready  in   1      fetch stage accepts pc_out this cycle
//  call         in   1      push PC+1, jump to load_addr (CALL_STACK_EN only)
//  ret          in   1      pop stack into PC (CALL_STACK_EN only)
//  pc_out       out  WIDTH  current PC
//  pc_valid     out  1      pc_out is valid for fetch
//  stack_full   out  1      return stack full
//  stack_empty  out  1      return stack empty
// BEHAVIOUR
//  Reset (async, any time incl. mid-operation): pc_out=RESET_VEC, pc_valid=0, state=IDLE,
//   stack pointer=0, stack_full=0, stack_empty=1. Pending requests discarded.
//  IDLE: first clk edge after rst deasserts -> RUN, pc_valid=1, pc_out unchanged.
//  RUN: accept = pc_valid & fetch_ready. Per edge, priority high->low:
//   1 halt                 -> HALT, pc_valid=0, pc_out held
//   2 load                 -> pc_out=load_addr (redirect, ignores fetch_ready), pc_valid=1
//   3 call/ret (macro on)  -> see CONFIGURATION
//   4 inc & accept         -> pc_out=pc_out+1, modulo 2^WIDTH (all-ones wraps to 0)
//   5 otherwise            -> hold; pc_out/pc_valid stable while fetch_ready=0
//  HALT: pc_valid=0; only load exits -> RUN with pc_out=load_addr, pc_valid=1 next cycle.
//   inc/call/ret ignored in HALT.
//  Latency: request sampled at edge N, new pc_out visible after edge N (1 cycle).
//  Valid/ready: pc_out must not change while pc_valid=1 & fetch_ready=0, except on load/halt.
//  Simultaneous load+inc: load wins, no increment. halt+load in RUN: halt wins.
//  All outputs registered; no combinational input->output path.
// CONFIGURATION
//  Macro CALL_STACK_EN:
//   defined: STACK_DEPTH x WIDTH LIFO. call (priority 3, needs accept) pushes pc_out+1,
//    pc_out=load_addr. ret (priority 3, needs accept) pops top into pc_out.
//    call+ret same cycle: call wins. call when full: push dropped, jump still taken,
//    stack unchanged. ret when empty: treated as inc. Flags update same edge as pointer.
//   undefined: no stack storage; call/ret ignored; stack_full=0, stack_empty=1 constantly.
// TESTING
//  1 rst=1 mid-run at pc=0x0042 -> pc_out=0x0000, pc_valid=0 immediately; one edge after
//    release pc_valid=1, pc_out=0x0000.
//  2 inc=1, fetch_ready=1 for 5 cycles -> pc_out 0..5; fetch_ready=0 2 cycles -> holds 5.
//  3 pc=0xFFFF, inc+accept -> pc_out=0x0000; load=1,inc=1,load_addr=0x1234 -> 0x1234.
//  4 halt=1 at pc=0x0010 -> pc_valid=0, inc ignored 3 cycles; load 0x0200 -> RUN, 0x0200.
//  5 CALL_STACK_EN: pc=0x0100 call to 0x0800 -> pc 0x0800; ret -> 0x0101; 5 calls with
//    DEPTH=4 -> stack_full=1 after 4th, 5th jumps but push dropped; ret on empty -> PC+1.
//  6 Macro undefined: call=1 ret=1 -> behaves as inc/hold only, stack_empty stays 1.

Source files
------------

// File: rtl/pc_seq.sv
// Program-counter sequencer for the fetch stage: IDLE/RUN/HALT FSM with a valid/ready PC offer.
// Define CALL_STACK_EN to build the hardware return-address stack (call/ret).
module pc_seq #(
    parameter int                 WIDTH       = 16,
    parameter logic [WIDTH-1:0]   RESET_VEC   = '0,
    parameter int                 STACK_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_addr,
    input  logic             inc,
    input  logic             halt,
    input  logic             fetch_ready,
    input  logic             call,
    input  logic             ret,
    output logic [WIDTH-1:0] pc_out,
    output logic             pc_valid,
    output logic             stack_full,
    output logic             stack_empty
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALT
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_pc_nxt;
    logic             r_valid;
    logic             w_valid_nxt;
    logic             w_accept;
    logic             w_push;
    logic             w_pop;

    assign w_accept = r_valid & fetch_ready;

`ifdef CALL_STACK_EN
    localparam int               SP_W    = $clog2(STACK_DEPTH) + 1;
    localparam logic [SP_W-1:0]  DEPTH_L = SP_W'(STACK_DEPTH);

    logic [WIDTH-1:0] r_stack [STACK_DEPTH];
    logic [SP_W-1:0]  r_sp;
    logic [SP_W-1:0]  w_sp_nxt;
    logic [SP_W-1:0]  w_sp_m1;
    logic [WIDTH-1:0] w_top;
    logic             r_full;
    logic             r_empty;

    assign w_sp_m1 = r_sp - SP_W'(1);
    assign w_top   = r_stack[w_sp_m1[SP_W-2:0]];
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_valid_nxt = r_valid;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_state_nxt = S_RUN;
                w_valid_nxt = 1'b1;
            end
            S_RUN: begin
                if (halt) begin
                    w_state_nxt = S_HALT;
                    w_valid_nxt = 1'b0;
                end else if (load) begin
                    w_pc_nxt    = load_addr;
                    w_valid_nxt = 1'b1;
                end
`ifdef CALL_STACK_EN
                else if (w_accept && call) begin
                    // A full stack drops the push but the jump still happens
                    w_pc_nxt = load_addr;
                    w_push   = ~r_full;
                end else if (w_accept && ret) begin
                    if (r_empty) begin
                        w_pc_nxt = r_pc + ONE;
                    end else begin
                        w_pc_nxt = w_top;
                        w_pop    = 1'b1;
                    end
                end
`endif
                else if (inc && w_accept) begin
                    w_pc_nxt = r_pc + ONE;
                end
            end
            S_HALT: begin
                if (load) begin
                    w_state_nxt = S_RUN;
                    w_pc_nxt    = load_addr;
                    w_valid_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_VEC;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_valid <= w_valid_nxt;
        end
    end

`ifdef CALL_STACK_EN
    always_comb begin
        w_sp_nxt = r_sp;
        if (w_push) begin
            w_sp_nxt = r_sp + SP_W'(1);
        end else if (w_pop) begin
            w_sp_nxt = w_sp_m1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sp    <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            r_sp    <= w_sp_nxt;
            r_full  <= (w_sp_nxt == DEPTH_L);
            r_empty <= (w_sp_nxt == '0);
        end
    end

    // Storage needs no reset; the pointer alone defines what is live
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stack[r_sp[SP_W-2:0]] <= r_pc + ONE;
        end
    end

    assign stack_full  = r_full;
    assign stack_empty = r_empty;
`else
    logic w_unused;
    assign w_unused = ^{call, ret, w_push, w_pop, STACK_DEPTH[0]};

    assign stack_full  = 1'b0;
    assign stack_empty = 1'b1;
`endif

    assign pc_out   = r_pc;
    assign pc_valid = r_valid;

endmodule

// File: tb/tb_pc_seq.sv
// Bench for pc_seq: directed scenarios then randomized traffic against a queue-based model.
// Follows the DUT build: define CALL_STACK_EN for both to exercise the return stack.
module tb_pc_seq;

    localparam int W = 16;
    localparam int D = 4;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         load;
    logic [W-1:0] load_addr;
    logic         inc;
    logic         halt;
    logic         fetch_ready;
    logic         call;
    logic         ret;
    logic [W-1:0] pc_out;
    logic         pc_valid;
    logic         stack_full;
    logic         stack_empty;

    int checks = 0;
    int errors = 0;

    int m_mode;
    int m_pc;
    bit m_valid;
    int m_stk[$];

    always #5 clk = ~clk;

    pc_seq #(
        .WIDTH      (W),
        .RESET_VEC  (16'h0000),
        .STACK_DEPTH(D)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_addr  (load_addr),
        .inc        (inc),
        .halt       (halt),
        .fetch_ready(fetch_ready),
        .call       (call),
        .ret        (ret),
        .pc_out     (pc_out),
        .pc_valid   (pc_valid),
        .stack_full (stack_full),
        .stack_empty(stack_empty)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        bit e_full;
        bit e_empty;
`ifdef CALL_STACK_EN
        e_full  = (m_stk.size() == D);
        e_empty = (m_stk.size() == 0);
`else
        e_full  = 1'b0;
        e_empty = 1'b1;
`endif
        check({tag, ".pc"}, 32'(pc_out), 32'(m_pc[W-1:0]));
        check({tag, ".valid"}, 32'(pc_valid), 32'(m_valid));
        check({tag, ".full"}, 32'(stack_full), 32'(e_full));
        check({tag, ".empty"}, 32'(stack_empty), 32'(e_empty));
    endtask

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_pc    = 0;
        m_valid = 1'b0;
        m_stk.delete();
    endtask

    // One clock edge of the architectural behaviour, highest priority first
    task automatic model_edge();
        bit acc;
        acc = m_valid && fetch_ready;
        if (m_mode == M_IDLE) begin
            m_mode  = M_RUN;
            m_valid = 1'b1;
        end else if (m_mode == M_HALT) begin
            if (load) begin
                m_mode  = M_RUN;
                m_pc    = int'(load_addr);
                m_valid = 1'b1;
            end
        end else if (halt) begin
            m_mode  = M_HALT;
            m_valid = 1'b0;
        end else if (load) begin
            m_pc = int'(load_addr);
`ifdef CALL_STACK_EN
        end else if (acc && call) begin
            if (m_stk.size() < D) m_stk.push_back((m_pc + 1) % 65536);
            m_pc = int'(load_addr);
        end else if (acc && ret) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else m_pc = (m_pc + 1) % 65536;
`endif
        end else if (acc && inc) begin
            m_pc = (m_pc + 1) % 65536;
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        if (!rst) model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic clear_in();
        load        = 1'b0;
        load_addr   = '0;
        inc         = 1'b0;
        halt        = 1'b0;
        fetch_ready = 1'b0;
        call        = 1'b0;
        ret         = 1'b0;
    endtask

    task automatic async_reset(input string tag);
        rst = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        clear_in();
        rst = 1'b1;
        model_reset();
        #12;
        check_all("reset");
        rst = 1'b0;
        step("idle2run");

        load = 1'b1; load_addr = 16'h0042; fetch_ready = 1'b1;
        step("load42");
        load = 1'b0;
        step("hold42");
        #3;
        async_reset("midrun_rst");
        step("post_rst");

        inc = 1'b1;
        repeat (5) step("inc_run");
        fetch_ready = 1'b0;
        repeat (2) step("stall_hold");

        load = 1'b1; load_addr = 16'hFFFF; fetch_ready = 1'b1; inc = 1'b0;
        step("load_ffff");
        load = 1'b0; inc = 1'b1;
        step("wrap");
        load = 1'b1; load_addr = 16'h1234;
        step("load_beats_inc");

        load_addr = 16'h0010; inc = 1'b0;
        step("load10");
        load = 1'b0; halt = 1'b1;
        step("halt");
        halt = 1'b0; inc = 1'b1;
        repeat (3) step("halt_ign_inc");
        load = 1'b1; load_addr = 16'h0200;
        step("halt_exit");
        load = 1'b0; inc = 1'b0;
        step("run_again");
        halt = 1'b1; load = 1'b1; load_addr = 16'h0777;
        step("halt_beats_load");
        halt = 1'b0;
        step("halt_load_exit");
        load = 1'b0;

`ifdef CALL_STACK_EN
        load = 1'b1; load_addr = 16'h0100;
        step("load100");
        load = 1'b0; call = 1'b1; load_addr = 16'h0800;
        step("call800");
        call = 1'b0; ret = 1'b1;
        step("ret101");
        ret = 1'b0; call = 1'b1;
        for (int i = 0; i < 5; i++) begin
            load_addr = 16'(16'h1000 + 16'(i) * 16'h0100);
            step("call_fill");
        end
        call = 1'b0; ret = 1'b1;
        repeat (5) step("ret_drain");
        ret = 1'b0;
`else
        call = 1'b1; ret = 1'b1; inc = 1'b0;
        repeat (2) step("nostk_hold");
        inc = 1'b1;
        repeat (2) step("nostk_inc");
        call = 1'b0; ret = 1'b0; inc = 1'b0;
`endif

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 63) == 0) begin
                async_reset("rand_rst");
            end
            load        = ($urandom_range(0, 7) == 0);
            load_addr   = W'($urandom);
            halt        = ($urandom_range(0, 15) == 0);
            inc         = ($urandom_range(0, 1) == 1);
            fetch_ready = ($urandom_range(0, 9) < 7);
            call        = ($urandom_range(0, 7) == 0);
            ret         = ($urandom_range(0, 7) == 0);
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
